// File: rtl/ft245r_tx_fifo.sv
// FT245R transmit path: small circular FIFO from fabric logic, drained one
// byte at a time onto the shared FT245R bus with a SETUP/STROBE/HOLD/BLANK
// write cycle. TXE# is synchronised and only consulted while idle.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | bus released; wait for a buffered byte, TXE# low, no read
// S_SETUP  | data and oe driven, wr low
// S_STROBE | wr high
// S_HOLD   | wr low, data still driven; head popped on the first cycle
// S_BLANK  | bus released; TXE# ignored while the FT updates it
module ft245r_tx_fifo #(
    parameter int FIFO_DEPTH     = 16,
    parameter int SETUP_CYCLES   = 1,
    parameter int WR_HIGH_CYCLES = 2,
    parameter int HOLD_CYCLES    = 1,
    parameter int TXE_BLANK      = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [7:0]                    i_in_data,
    input  logic                          i_in_valid,
    output logic                          o_in_ready,
    input  logic                          i_txe_,
    input  logic                          i_rd_active,
    output logic [7:0]                    o_usb_dout,
    output logic                          o_usb_oe,
    output logic                          o_wr,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_BLANK
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [TW-1:0]   r_phase;
    logic [TW-1:0]   w_phase_load;
    logic            w_phase_tc;
    logic            w_start;

    logic            r_txe_s1;
    logic            r_txe_s2;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    logic [7:0]      r_dout;
    logic            r_oe;
    logic            r_wr;

    assign o_in_ready   = (r_count != CW'(FIFO_DEPTH));
    assign w_push       = i_in_valid & o_in_ready;
    assign w_phase_tc   = (r_phase == '0);
    // The head leaves the FIFO on the first HOLD cycle; the FT has latched it on wr fall.
    assign w_pop        = (r_state == S_HOLD) && (r_phase == TW'(HOLD_CYCLES - 1));
    assign o_fifo_count = r_count;
    assign o_busy       = (r_state != S_IDLE);
    assign o_usb_dout   = r_dout;
    assign o_usb_oe     = r_oe;
    assign o_wr         = r_wr;

    // Two-flop synchroniser for the asynchronous TXE# input.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_txe_s1 <= 1'b1;
            r_txe_s2 <= 1'b1;
        end else begin
            r_txe_s1 <= i_txe_;
            r_txe_s2 <= r_txe_s1;
        end
    end

    // FIFO storage; contents need no reset since the count gates every read.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_tail] <= i_in_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Next-state decode; each phase reloads the down-counter on entry.
    always_comb begin
        w_state_next = r_state;
        w_phase_load = '0;
        w_start      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((r_count != '0) && !r_txe_s2 && !i_rd_active) begin
                    w_state_next = S_SETUP;
                    w_phase_load = TW'(SETUP_CYCLES - 1);
                    w_start      = 1'b1;
                end
            end
            S_SETUP: begin
                if (w_phase_tc) begin
                    w_state_next = S_STROBE;
                    w_phase_load = TW'(WR_HIGH_CYCLES - 1);
                end
            end
            S_STROBE: begin
                if (w_phase_tc) begin
                    w_state_next = S_HOLD;
                    w_phase_load = TW'(HOLD_CYCLES - 1);
                end
            end
            S_HOLD: begin
                if (w_phase_tc) begin
                    w_state_next = S_BLANK;
                    w_phase_load = TW'(TXE_BLANK - 1);
                end
            end
            S_BLANK: begin
                if (w_phase_tc) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, phase counter and registered (glitch-free) bus controls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_phase <= '0;
            r_dout  <= '0;
            r_oe    <= 1'b0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next != r_state) begin
                r_phase <= w_phase_load;
            end else if (!w_phase_tc) begin
                r_phase <= r_phase - TW'(1);
            end
            if (w_start) begin
                r_dout <= r_mem[r_head];
            end
            r_oe <= (w_state_next == S_SETUP) || (w_state_next == S_STROBE) ||
                    (w_state_next == S_HOLD);
            r_wr <= (w_state_next == S_STROBE);
        end
    end

endmodule

// File: tb/tb_ft245r_tx_fifo.sv
// Self-checking bench for ft245r_tx_fifo: scoreboard of pushed bytes checked
// against usb_dout at every wr rising edge, plus per-scenario checks.
module tb_ft245r_tx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       txe_n = 1'b1;
    logic       rd_active = 1'b0;
    logic [7:0] usb_dout;
    logic       usb_oe;
    logic       wr;
    logic [4:0] fifo_count;
    logic       busy;

    logic [7:0] sb[$];
    int         rise_cyc[$];
    int         n_rise = 0;
    int         cyc = 0;
    int         vectors = 0;
    int         errs = 0;
    bit         prev_wr = 1'b0;

    ft245r_tx_fifo dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_in_data    (in_data),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_txe_       (txe_n),
        .i_rd_active  (rd_active),
        .o_usb_dout   (usb_dout),
        .o_usb_oe     (usb_oe),
        .o_wr         (wr),
        .o_fifo_count (fifo_count),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every wr rising edge must present the oldest expected byte with oe high.
    always @(negedge clk) begin
        if (rst) begin
            prev_wr = 1'b0;
        end else begin
            if (wr && !prev_wr) begin
                n_rise++;
                rise_cyc.push_back(cyc);
                vectors++;
                if (sb.size() == 0) begin
                    errs++;
                    $display("FAIL wr_unexpected: wr rose with data %02h, required no write", usb_dout);
                end else begin
                    logic [7:0] exp_b;
                    exp_b = sb.pop_front();
                    if (usb_dout !== exp_b || usb_oe !== 1'b1) begin
                        errs++;
                        $display("FAIL wr_data: dout=%02h oe=%b, required dout=%02h oe=1", usb_dout, usb_oe, exp_b);
                    end
                end
            end
            prev_wr = wr;
        end
    end

    task automatic push(input logic [7:0] d, input bit expect_accept);
        in_valid = 1'b1;
        in_data  = d;
        if (expect_accept) sb.push_back(d);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk); #1;
            if (sb.size() == 0 && !busy && fifo_count == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (wr !== 1'b0 || usb_oe !== 1'b0 || usb_dout !== 8'h00 || busy !== 1'b0 ||
            fifo_count !== 5'd0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset: wr=%b oe=%b dout=%02h busy=%b cnt=%0d rdy=%b, required 0 0 00 0 0 1",
                     wr, usb_oe, usb_dout, busy, fifo_count, in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int  oe_n = 0;
        int  wr_n = 0;
        bit  dbad = 1'b0;
        txe_n = 1'b0;
        push(8'hA5, 1'b1);
        vectors++;
        if (fifo_count !== 5'd1) begin
            errs++;
            $display("FAIL single_count_after_push: %0d, required 1", fifo_count);
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (usb_oe) begin
                oe_n++;
                if (usb_dout !== 8'hA5) dbad = 1'b1;
            end
            if (wr) wr_n++;
        end
        vectors++;
        if (oe_n != 4 || wr_n != 2 || dbad) begin
            errs++;
            $display("FAIL single_strobe: oe=%0d wr=%0d dout_bad=%b, required 4 2 0", oe_n, wr_n, dbad);
        end
        vectors++;
        if (fifo_count !== 5'd0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL single_drained: cnt=%0d busy=%b, required 0 0", fifo_count, busy);
        end
    endtask

    task automatic test_fill_and_drain();
        bit ok;
        int rdy_bad = 0;
        txe_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            vectors++;
            if (in_ready !== (i < 16)) begin
                errs++; rdy_bad++;
                $display("FAIL fill_ready[%0d]: %b, required %b", i, in_ready, (i < 16));
            end
            push(8'(i), i < 16);
        end
        vectors++;
        if (fifo_count !== 5'd16 || in_ready !== 1'b0) begin
            errs++;
            $display("FAIL fill_full: cnt=%0d rdy=%b, required 16 0", fifo_count, in_ready);
        end
        #1;
        rise_cyc.delete();
        txe_n = 1'b0;
        wait_idle(400, ok);
        vectors++;
        if (!ok || rise_cyc.size() != 16) begin
            errs++;
            $display("FAIL fill_drain: done=%b writes=%0d, required 1 16", ok, rise_cyc.size());
        end
        for (int i = 1; i < rise_cyc.size(); i++) begin
            vectors++;
            if (rise_cyc[i] - rise_cyc[i-1] != 9) begin
                errs++;
                $display("FAIL fill_spacing[%0d]: %0d clks, required 9", i, rise_cyc[i] - rise_cyc[i-1]);
            end
        end
    endtask

    task automatic test_txe_pause();
        bit ok;
        bit hit = 1'b0;
        int base = n_rise;
        txe_n = 1'b0;
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        push(8'h33, 1'b1);
        push(8'h44, 1'b1);
        for (int i = 0; i < 60; i++) begin
            if (n_rise == base + 2) begin hit = 1'b1; break; end
            @(negedge clk); #1;
        end
        vectors++;
        if (!hit || wr !== 1'b1) begin
            errs++;
            $display("FAIL pause_second_strobe: reached=%b wr=%b, required 1 1", hit, wr);
        end
        txe_n = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        vectors++;
        if (n_rise != base + 2 || fifo_count !== 5'd2 || busy !== 1'b0) begin
            errs++;
            $display("FAIL pause_hold: writes=%0d cnt=%0d busy=%b, required 2 2 0", n_rise - base, fifo_count, busy);
        end
        txe_n = 1'b0;
        wait_idle(100, ok);
        vectors++;
        if (!ok || n_rise != base + 4) begin
            errs++;
            $display("FAIL pause_resume: done=%b writes=%0d, required 1 4", ok, n_rise - base);
        end
    endtask

    task automatic test_rd_active();
        bit ok;
        bit oe_seen = 1'b0;
        int base = n_rise;
        rd_active = 1'b1;
        txe_n = 1'b0;
        push(8'hC1, 1'b1);
        push(8'hC2, 1'b1);
        push(8'hC3, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (usb_oe || wr) oe_seen = 1'b1;
        end
        vectors++;
        if (oe_seen || n_rise != base || fifo_count !== 5'd3) begin
            errs++;
            $display("FAIL rd_block: bus_driven=%b writes=%0d cnt=%0d, required 0 0 3", oe_seen, n_rise - base, fifo_count);
        end
        rd_active = 1'b0;
        wait_idle(100, ok);
        vectors++;
        if (!ok || n_rise != base + 3) begin
            errs++;
            $display("FAIL rd_release: done=%b writes=%0d, required 1 3", ok, n_rise - base);
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        txe_n = 1'b0;
        push(8'h77, 1'b1);
        push(8'h88, 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (wr) begin hit = 1'b1; break; end
        end
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        vectors++;
        if (!hit || wr !== 1'b0 || usb_oe !== 1'b0 || fifo_count !== 5'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_mid: strobe_seen=%b wr=%b oe=%b cnt=%0d busy=%b rdy=%b, required 1 0 0 0 0 1",
                     hit, wr, usb_oe, fifo_count, busy, in_ready);
        end
        rst = 1'b0;
        txe_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_push_on_pop();
        bit ok;
        bit hit = 1'b0;
        int base = n_rise;
        push(8'h3C, 1'b1);
        #1;
        txe_n = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (n_rise == base + 1) begin hit = 1'b1; break; end
        end
        @(negedge clk); #1;
        @(negedge clk); #1;
        vectors++;
        if (!hit || wr !== 1'b0 || usb_oe !== 1'b1 || fifo_count !== 5'd1) begin
            errs++;
            $display("FAIL pop_hold_entry: strobe_seen=%b wr=%b oe=%b cnt=%0d, required 1 0 1 1", hit, wr, usb_oe, fifo_count);
        end
        in_valid = 1'b1;
        in_data  = 8'h5A;
        sb.push_back(8'h5A);
        @(negedge clk); #1;
        in_valid = 1'b0;
        vectors++;
        if (fifo_count !== 5'd1) begin
            errs++;
            $display("FAIL pop_push_same: cnt=%0d, required 1", fifo_count);
        end
        wait_idle(60, ok);
        vectors++;
        if (!ok || n_rise != base + 2) begin
            errs++;
            $display("FAIL pop_next_byte: done=%b writes=%0d, required 1 2", ok, n_rise - base);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_fill_and_drain();
        test_txe_pause();
        test_rd_active();
        test_reset_mid();
        test_push_on_pop();
        vectors++;
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL scoreboard_leftover: %0d bytes, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
